// File: rtl/systolic_array.sv
// Weight-stationary NxN fixed-point MAC array with double-buffered (shadow/active) weights.
// Latency: column c result N-1+c cycles after row 0 is sampled; no backpressure, one vector per cycle.
module systolic_array #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int SAT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*DW-1:0]          sys_data_in,
    input  logic [N-1:0]             sys_valid_in,
    input  logic [N*DW-1:0]          sys_weight_in,
    input  logic [N-1:0]             sys_accept_w,
    input  logic                     sys_switch_in,
    input  logic [$clog2(N+1)-1:0]   ub_rd_col_size_in,
    input  logic                     ub_rd_col_size_valid_in,
    output logic [N*DW-1:0]          sys_data_out,
    output logic [N-1:0]             sys_valid_out,
    output logic                     sys_busy
);
    localparam int CW = $clog2(N+1);
    localparam logic signed [2*DW:0] SAT_MAX = $signed({{(DW+2){1'b0}}, {(DW-1){1'b1}}});
    localparam logic signed [2*DW:0] SAT_MIN = $signed({{(DW+2){1'b1}}, {(DW-1){1'b0}}});

    logic signed [DW-1:0] shadow_w_q [N][N], shadow_w_d [N][N];
    logic signed [DW-1:0] active_w_q [N][N], active_w_d [N][N];
    logic signed [DW-1:0] in_reg_q   [N][N], in_reg_d   [N][N];
    logic signed [DW-1:0] psum_q     [N][N], psum_d     [N][N];
    logic                 in_vld_q   [N][N], in_vld_d   [N][N];
    logic                 sw_q       [N][N], sw_d       [N][N];
    logic [CW-1:0]        col_size_q, col_size_d;

    logic signed [DW-1:0] cell_din [N][N];
    logic signed [DW-1:0] cell_pin [N][N];
    logic signed [DW-1:0] cell_win [N][N];
    logic                 cell_vin [N][N];
    logic                 cell_sin [N][N];
    logic [N-1:0]         col_en;

    // Full-precision product, rescaled, then added with one guard bit before clamp/wrap.
    function automatic logic signed [DW-1:0] acc(input logic signed [DW-1:0] p_in,
                                                 input logic signed [DW-1:0] d_in,
                                                 input logic signed [DW-1:0] w_in);
        logic signed [2*DW-1:0] prod;
        logic signed [2*DW-1:0] prod_sh;
        logic signed [2*DW:0]   ext;
        prod    = $signed({{DW{d_in[DW-1]}}, d_in}) * $signed({{DW{w_in[DW-1]}}, w_in});
        prod_sh = prod >>> FRAC;
        ext     = $signed({{(DW+1){p_in[DW-1]}}, p_in}) + $signed({prod_sh[2*DW-1], prod_sh});
        if (SAT != 0 && ext > SAT_MAX)
            acc = {1'b0, {(DW-1){1'b1}}};
        else if (SAT != 0 && ext < SAT_MIN)
            acc = {1'b1, {(DW-1){1'b0}}};
        else
            acc = ext[DW-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < N; c++) begin
            col_en[c]      = (c < int'(col_size_q));
            cell_pin[0][c] = '0;
            cell_win[0][c] = sys_weight_in[c*DW +: DW];
        end
        for (int r = 0; r < N; r++) begin
            cell_din[r][0] = sys_data_in[r*DW +: DW];
            cell_vin[r][0] = sys_valid_in[r];
            for (int c = 1; c < N; c++) begin
                cell_din[r][c] = in_reg_q[r][c-1];
                cell_vin[r][c] = in_vld_q[r][c-1];
                cell_sin[r][c] = sw_q[r][c-1];
            end
        end
        for (int r = 1; r < N; r++) begin
            cell_sin[r][0] = sw_q[r-1][0];
            for (int c = 0; c < N; c++) begin
                cell_pin[r][c] = psum_q[r-1][c];
                cell_win[r][c] = shadow_w_q[r-1][c];
            end
        end
        // The switch enters at the corner, walks down column 0, then across each row.
        cell_sin[0][0] = sys_switch_in;
    end

    always_comb begin
        col_size_d = col_size_q;
        if (ub_rd_col_size_valid_in)
            col_size_d = (int'(ub_rd_col_size_in) > N) ? CW'(N) : ub_rd_col_size_in;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                shadow_w_d[r][c] = sys_accept_w[c] ? cell_win[r][c] : shadow_w_q[r][c];
                active_w_d[r][c] = cell_sin[r][c] ? shadow_w_q[r][c] : active_w_q[r][c];
                sw_d[r][c]       = cell_sin[r][c];
                in_reg_d[r][c]   = col_en[c] ? cell_din[r][c] : '0;
                in_vld_d[r][c]   = col_en[c] & cell_vin[r][c];
                psum_d[r][c]     = (col_en[c] && cell_vin[r][c])
                                 ? acc(cell_pin[r][c], cell_din[r][c], active_w_q[r][c]) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_size_q <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    shadow_w_q[r][c] <= '0;
                    active_w_q[r][c] <= '0;
                    sw_q[r][c]       <= 1'b0;
                    in_reg_q[r][c]   <= '0;
                    in_vld_q[r][c]   <= 1'b0;
                    psum_q[r][c]     <= '0;
                end
            end
        end else begin
            col_size_q <= col_size_d;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    shadow_w_q[r][c] <= shadow_w_d[r][c];
                    active_w_q[r][c] <= active_w_d[r][c];
                    sw_q[r][c]       <= sw_d[r][c];
                    in_reg_q[r][c]   <= in_reg_d[r][c];
                    in_vld_q[r][c]   <= in_vld_d[r][c];
                    psum_q[r][c]     <= psum_d[r][c];
                end
            end
        end
    end

    always_comb begin
        sys_data_out  = '0;
        sys_valid_out = '0;
        sys_busy      = 1'b0;
        for (int c = 0; c < N; c++) begin
            sys_data_out[c*DW +: DW] = psum_q[N-1][c];
            sys_valid_out[c]         = in_vld_q[N-1][c];
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                sys_busy = sys_busy | in_vld_q[r][c];
    end
endmodule

// File: tb/tb_systolic_array.sv
// Randomised scoreboard bench for systolic_array; a saturating and a wrapping instance share stimulus.
// Expected psums come from plain integer dot products over the weight matrix active when a vector enters.
module tb_systolic_array;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int CW   = $clog2(N+1);

    typedef logic [N-1:0][DW-1:0]        row_t;
    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
    typedef struct packed { logic [DW-1:0] s; logic [DW-1:0] w; int e; } exp_t;
    typedef struct packed { int s; int e; } iv_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] sys_data_in, sys_weight_in;
    logic [N-1:0]    sys_valid_in, sys_accept_w;
    logic            sys_switch_in;
    logic [CW-1:0]   col_in;
    logic            col_vld;
    logic [N*DW-1:0] dout_s, dout_w;
    logic [N-1:0]    vout_s, vout_w;
    logic            busy_s, busy_w;

    systolic_array #(.N(N), .DW(DW), .FRAC(FRAC), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
        .sys_weight_in(sys_weight_in), .sys_accept_w(sys_accept_w), .sys_switch_in(sys_switch_in),
        .ub_rd_col_size_in(col_in), .ub_rd_col_size_valid_in(col_vld),
        .sys_data_out(dout_s), .sys_valid_out(vout_s), .sys_busy(busy_s));

    systolic_array #(.N(N), .DW(DW), .FRAC(FRAC), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
        .sys_weight_in(sys_weight_in), .sys_accept_w(sys_accept_w), .sys_switch_in(sys_switch_in),
        .ub_rd_col_size_in(col_in), .ub_rd_col_size_valid_in(col_vld),
        .sys_data_out(dout_w), .sys_valid_out(vout_w), .sys_busy(busy_w));

    always #5 clk = ~clk;

    mat_t  mshadow, mactive;
    int    mcol;
    row_t  sk [N];
    bit    skv [N];
    exp_t  exp_q [N][$];
    iv_t   busy_q [$];
    int    n_cmp = 0, n_bad = 0, edge_cnt = 0;
    bit    mon_en = 1'b0;
    int    cnt_hi = 0, cnt_any = 0, cnt_c3 = 0;
    logic [DW-1:0] last_s0, last_w0;
    bit    gen_on = 1'b0, gen_fixed_on = 1'b0;
    int    gen_pct = 100;
    row_t  gen_fixed;

    function automatic longint fix(longint v, bit sat);
        longint hi, lo;
        hi = (longint'(1) <<< (DW-1)) - 1;
        lo = -(longint'(1) <<< (DW-1));
        if (sat) return (v > hi) ? hi : ((v < lo) ? lo : v);
        return (v <<< (64-DW)) >>> (64-DW);
    endfunction

    function automatic exp_t model_col(row_t x, int c, int e);
        longint ps = 0, pw = 0, prod;
        exp_t   r;
        for (int i = 0; i < N; i++) begin
            prod = longint'($signed(x[i])) * longint'($signed(mactive[i][c]));
            ps = fix(ps + (prod >>> FRAC), 1'b1);
            pw = fix(pw + (prod >>> FRAC), 1'b0);
        end
        r.s = DW'(ps);
        r.w = DW'(pw);
        r.e = e;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_val();
        if ($urandom_range(3) == 0) return DW'($urandom);
        return DW'(int'($urandom_range(2047)) - 1024);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dout_sat"},  64'(dout_s), 64'd0);
        check({tag, "_dout_wrap"}, 64'(dout_w), 64'd0);
        check({tag, "_vout_sat"},  64'(vout_s), 64'd0);
        check({tag, "_vout_wrap"}, 64'(vout_w), 64'd0);
        check({tag, "_busy_sat"},  64'(busy_s), 64'd0);
        check({tag, "_busy_wrap"}, 64'(busy_w), 64'd0);
    endtask

    // One input cycle: vectors enter skewed (row r r cycles late); expectation uses weights active on entry.
    task automatic cycle(input bit vv, input row_t x, input bit acc, input row_t wrow, input bit sw);
        for (int r = N-1; r > 0; r--) begin
            sk[r]  = sk[r-1];
            skv[r] = skv[r-1];
        end
        sk[0]  = x;
        skv[0] = vv;
        for (int r = 0; r < N; r++) begin
            sys_data_in[r*DW +: DW] = sk[r][r];
            sys_valid_in[r]         = skv[r];
        end
        if (vv && mcol > 0) begin
            for (int c = 0; c < mcol; c++)
                exp_q[c].push_back(model_col(x, c, edge_cnt + N + c));
            busy_q.push_back('{s: edge_cnt + 1, e: edge_cnt + N + mcol - 1});
        end
        if (sw) mactive = mshadow;
        if (acc) begin
            for (int r = N-1; r > 0; r--) mshadow[r] = mshadow[r-1];
            mshadow[0] = wrow;
        end
        sys_accept_w  = acc ? '1 : '0;
        sys_weight_in = wrow;
        sys_switch_in = sw;
        @(negedge clk);
    endtask

    task automatic tick(input bit acc, input row_t wrow, input bit sw);
        row_t x;
        bit   vv;
        vv = gen_on && ($urandom_range(99) < gen_pct);
        for (int r = 0; r < N; r++) x[r] = gen_fixed_on ? gen_fixed[r] : rand_val();
        cycle(vv, x, acc, wrow, sw);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0);
    endtask

    task automatic load_w(input mat_t w);
        for (int k = 0; k < N; k++) tick(1'b1, w[N-1-k], 1'b0);
    endtask

    task automatic load_switch(input mat_t w);
        load_w(w);
        tick(1'b0, '0, 1'b1);
        idle(2*N);
    endtask

    task automatic set_col(input int v);
        col_in  = CW'(v);
        col_vld = 1'b1;
        tick(1'b0, '0, 1'b0);
        col_vld = 1'b0;
        mcol    = (v > N) ? N : v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sys_valid_in = '0; sys_accept_w = '0; sys_switch_in = 1'b0; col_vld = 1'b0;
        for (int r = 0; r < N; r++) begin sk[r] = '0; skv[r] = 1'b0; end
        for (int c = 0; c < N; c++) exp_q[c].delete();
        busy_q.delete();
        mshadow = '0; mactive = '0; mcol = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic mat_t rand_mat();
        mat_t w;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) w[r][c] = rand_val();
        return w;
    endfunction

    // Monitor: samples 1 time unit after each rising edge, pops per-column expectations.
    always @(posedge clk) begin
        exp_t e;
        bit   be;
        edge_cnt++;
        #1;
        if (mon_en) begin
            for (int c = 0; c < N; c++) begin
                while (exp_q[c].size() > 0 && exp_q[c][0].e < edge_cnt) begin
                    e = exp_q[c].pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL missing_output col%0d: got no valid by edge %0d, required result %h at edge %0d",
                             c, edge_cnt, e.s, e.e);
                end
                if (vout_s[c] || vout_w[c]) begin
                    n_cmp++;
                    if (exp_q[c].size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_valid col%0d edge %0d: got valid sat=%b wrap=%b, required none",
                                 c, edge_cnt, vout_s[c], vout_w[c]);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (!(vout_s[c] === 1'b1 && vout_w[c] === 1'b1 && dout_s[c*DW +: DW] === e.s &&
                              dout_w[c*DW +: DW] === e.w && edge_cnt == e.e)) begin
                            n_bad++;
                            $display("FAIL col%0d_result: got sat=%h wrap=%h vld=%b%b at edge %0d, required sat=%h wrap=%h at edge %0d",
                                     c, dout_s[c*DW +: DW], dout_w[c*DW +: DW], vout_s[c], vout_w[c],
                                     edge_cnt, e.s, e.w, e.e);
                        end
                    end
                end
            end
            while (busy_q.size() > 0 && busy_q[0].e < edge_cnt) void'(busy_q.pop_front());
            be = 1'b0;
            foreach (busy_q[i]) if (busy_q[i].s <= edge_cnt && edge_cnt <= busy_q[i].e) be = 1'b1;
            n_cmp++;
            if (busy_s !== be || busy_w !== be) begin
                n_bad++;
                $display("FAIL busy edge %0d: got sat=%b wrap=%b, required %b", edge_cnt, busy_s, busy_w, be);
            end
            if (vout_s[N-1:2] != 0 || vout_w[N-1:2] != 0) cnt_hi++;
            if (vout_s != 0 || vout_w != 0) cnt_any++;
            if (vout_s[N-1]) cnt_c3++;
            if (vout_s[0]) last_s0 = dout_s[DW-1:0];
            if (vout_w[0]) last_w0 = dout_w[DW-1:0];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its end, required completion");
        $fatal(1);
    end

    initial begin
        mat_t w;
        rst = 1'b1; sys_data_in = '0; sys_valid_in = '0; sys_weight_in = '0;
        sys_accept_w = '0; sys_switch_in = 1'b0; col_in = '0; col_vld = 1'b0;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        check_zero_outputs("reset");

        // Identity weights pass the vector straight through.
        set_col(4);
        w = '0;
        for (int i = 0; i < N; i++) w[i][i] = 16'h0100;
        load_switch(w);
        for (int i = 0; i < N; i++) gen_fixed[i] = DW'((i + 1) * 256);
        gen_fixed_on = 1'b1; gen_on = 1'b1; gen_pct = 100;
        tick(1'b0, '0, 1'b0);
        gen_on = 1'b0;
        idle(3*N);

        // Random streams; next weights shifted in mid-stream, then switched mid-stream.
        gen_fixed_on = 1'b0;
        load_switch(rand_mat());
        for (int round = 0; round < 3; round++) begin
            gen_on = 1'b1; gen_pct = 75;
            idle(10);
            load_w(rand_mat());
            idle(3);
            tick(1'b0, '0, 1'b1);
            idle(2*N + 10);
            gen_on = 1'b0;
            idle(3*N);
        end

        // Column-size clipping.
        set_col(2);
        for (int i = 0; i < N; i++) gen_fixed[i] = 16'h0100;
        gen_fixed_on = 1'b1; gen_on = 1'b1; gen_pct = 100;
        cnt_hi = 0;
        idle(10);
        gen_on = 1'b0;
        idle(3*N);
        check("colsize2_upper_valids", 64'(cnt_hi), 64'd0);
        set_col(7);
        cnt_c3 = 0;
        gen_on = 1'b1;
        idle(6);
        gen_on = 1'b0;
        idle(3*N);
        check("colsize7_col3_valids", 64'(cnt_c3), 64'd6);

        // Saturation vs wrap: 0x7F00 * 0x0200 in rows 0 and 1 of column 0.
        w = '0;
        w[0][0] = 16'h0200; w[1][0] = 16'h0200;
        load_switch(w);
        gen_fixed = '0;
        gen_fixed[0] = 16'h7F00; gen_fixed[1] = 16'h7F00;
        gen_on = 1'b1;
        tick(1'b0, '0, 1'b0);
        gen_on = 1'b0;
        idle(3*N);
        check("sat_col0", 64'(last_s0), 64'h7FFF);
        check("wrap_col0", 64'(last_w0), 64'hFC00);

        // Reset two cycles into a stream.
        gen_fixed_on = 1'b0;
        load_switch(rand_mat());
        gen_on = 1'b1; gen_pct = 100;
        idle(2);
        do_reset();
        check_zero_outputs("midreset");
        cnt_any = 0;
        idle(3);
        gen_on = 1'b0;
        idle(3*N);
        check("post_reset_no_valid", 64'(cnt_any), 64'd0);

        // Fresh random traffic after reset.
        set_col(4);
        load_switch(rand_mat());
        gen_on = 1'b1; gen_pct = 70;
        idle(30);
        gen_on = 1'b0;
        idle(3*N);

        for (int c = 0; c < N; c++) check($sformatf("leftover_col%0d", c), 64'(exp_q[c].size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
